mem_bus_responder: RTL and testbench

Byte-wide memory-bus responder for the SRP16 core. It answers the control unit's one-cycle `mem_read`/`mem_write` strobes: it serves an on-chip byte RAM with configurable wait states and forwards a memory-mapped I/O window to an external req/ack port. It reports completion with `dout_valid` and backpressure with `busy`, so the control unit can stall its phase counter.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/mem_bus_responder_byte_ram.sv | 36 +++
 rtl/mem_bus_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_bus_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the SRP16 memory-bus responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_bus_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        IO_WAIT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Start of the memory-mapped I/O window; the window runs up to 16'hFFFF
    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

    // Data returned for reads that cannot be served normally
    localparam logic [7:0] RD_OOB_DATA     = 8'h00;
    localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

    // Shared wait/timeout counter width (WAIT_STATES and IO_TIMEOUT must fit)
    localparam int CNT_W = 8;

endpackage

// File: rtl/mem_bus_responder_byte_ram.sv
// Single-port byte RAM: synchronous write, registered read.
// Latency: read data appears the cycle after re; write commits on the same edge.
// Backpressure: none, one access per cycle.
// Ports: clk/reset (sync, active-low; clears only the read register),
//        we/re strobes, addr, wdata in, rdata out.
module byte_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Array contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Byte-wide memory-bus responder: internal RAM with wait states plus an I/O req/ack window.
// Latency: RAM read 1+WAIT_STATES cycles to dout_valid; RAM write zero-busy; I/O ack+1 or timeout.
// Backpressure: busy high while a transaction is in flight; strobes seen then are rejected with err.
// Ports: clk, reset (sync active-low); mem_read/mem_write/abus/din from the control unit;
//        dout/dout_valid/busy/err back to it; io_req/io_we/io_addr/io_wdata/io_rdata/io_ack to I/O.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int          RAM_DEPTH   = 4096,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] IO_BASE     = IO_BASE_DEFAULT,
    parameter int          IO_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] abus,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        busy,
    output logic        err,
    output logic        io_req,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic        io_ack
);

    localparam int          AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       dout_q;
    logic             dout_sel_ram;
    logic [7:0]       ram_rdata;

    // Address decode; the I/O window takes priority over any RAM overlap
    logic is_io, is_ram;
    assign is_io  = (abus >= IO_BASE);
    assign is_ram = !is_io && ({1'b0, abus} < RAM_LIMIT);

    logic idle, accept;
    assign idle   = (state == IDLE);
    // Exactly one strobe, in IDLE, out of reset
    assign accept = reset && idle && (mem_read ^ mem_write);

    logic ram_we, ram_re;
    assign ram_we = accept && mem_write && is_ram;
    assign ram_re = accept && mem_read  && is_ram;

    byte_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (abus[AW-1:0]),
        .wdata (din),
        .rdata (ram_rdata)
    );

    // RAM reads are returned straight from the RAM's read register (needed
    // for the zero-wait-state case); all other reads come from dout_q.
    // Both sources and the select are registers.
    assign dout = dout_sel_ram ? ram_rdata : dout_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            dout_q       <= 8'h00;
            dout_sel_ram <= 1'b0;
            dout_valid   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            io_req       <= 1'b0;
            io_we        <= 1'b0;
            io_addr      <= 8'h00;
            io_wdata     <= 8'h00;
        end else begin
            dout_valid <= 1'b0;
            // Protocol errors: both strobes together, or any strobe while busy
            err <= (mem_read | mem_write) & (!idle | (mem_read & mem_write));

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_io) begin
                            state    <= IO_WAIT;
                            busy     <= 1'b1;
                            io_req   <= 1'b1;
                            io_we    <= mem_write;
                            io_addr  <= abus[7:0];
                            io_wdata <= din;
                            cnt      <= CNT_W'(IO_TIMEOUT);
                        end else if (is_ram) begin
                            // Writes already committed in byte_ram this edge
                            if (mem_read) begin
                                busy         <= 1'b1;
                                dout_sel_ram <= 1'b1;
                                if (WAIT_STATES == 0) begin
                                    state      <= DONE;
                                    dout_valid <= 1'b1;
                                end else begin
                                    state <= RAM_WAIT;
                                    cnt   <= CNT_W'(WAIT_STATES);
                                end
                            end
                        end else begin
                            // Hole between RAM and I/O window
                            err <= 1'b1;
                            if (mem_read) begin
                                state        <= DONE;
                                busy         <= 1'b1;
                                dout_valid   <= 1'b1;
                                dout_q       <= RD_OOB_DATA;
                                dout_sel_ram <= 1'b0;
                            end
                        end
                    end
                end

                RAM_WAIT: begin
                    if (cnt <= 1) begin
                        state      <= DONE;
                        dout_valid <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                IO_WAIT: begin
                    // Ack wins over a timeout expiring on the same edge
                    if (io_ack) begin
                        io_req <= 1'b0;
                        cnt    <= '0;
                        if (!io_we) begin
                            state        <= DONE;
                            dout_valid   <= 1'b1;
                            dout_q       <= io_rdata;
                            dout_sel_ram <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (cnt <= 1) begin
                        io_req <= 1'b0;
                        err    <= 1'b1;
                        cnt    <= '0;
                        if (!io_we) begin
                            state        <= DONE;
                            dout_valid   <= 1'b1;
                            dout_q       <= RD_TIMEOUT_DATA;
                            dout_sel_ram <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder with WAIT_STATES=2, RAM_DEPTH=4096, IO_TIMEOUT=15.
// Latency: n/a.
// Backpressure: the bench plays the I/O responder, acking after a chosen delay or never.
module tb_mem_bus_responder;

    localparam int WS    = 2;
    localparam int TMO   = 15;
    localparam int DEPTH = 4096;
    localparam int NWIN  = 32;   // RAM addresses exercised by the random phase

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] abus = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        busy;
    logic        err;
    logic        io_req;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata = 8'h00;
    logic        io_ack = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference memory for the exercised RAM window
    logic [7:0] model_mem [NWIN];

    mem_bus_responder #(
        .RAM_DEPTH   (DEPTH),
        .WAIT_STATES (WS),
        .IO_BASE     (16'hFF00),
        .IO_TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .abus       (abus),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .err        (err),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_ack     (io_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".dout"},       16'(dout),       16'h00);
        chk({tag, ".dout_valid"}, 16'(dout_valid), 16'h0);
        chk({tag, ".busy"},       16'(busy),       16'h0);
        chk({tag, ".err"},        16'(err),        16'h0);
        chk({tag, ".io_req"},     16'(io_req),     16'h0);
        chk({tag, ".io_we"},      16'(io_we),      16'h0);
        chk({tag, ".io_addr"},    16'(io_addr),    16'h00);
        chk({tag, ".io_wdata"},   16'(io_wdata),   16'h00);
    endtask

    // Zero-busy RAM write; returns after one cycle so calls can be back-to-back
    task automatic ram_write(input logic [15:0] a, input logic [7:0] d);
        mem_write = 1'b1; abus = a; din = d;
        tick();
        mem_write = 1'b0;
        chk("wr.busy", 16'(busy), 16'h0);
        chk("wr.err",  16'(err),  16'h0);
        chk("wr.dv",   16'(dout_valid), 16'h0);
        if (a < NWIN) model_mem[a] = d;
    endtask

    // RAM read: busy for WS+1 cycles, dout_valid on the last of them
    task automatic ram_read(input logic [15:0] a);
        logic [7:0] exp;
        exp = model_mem[a];
        mem_read = 1'b1; abus = a;
        tick();
        mem_read = 1'b0;
        for (int k = 1; k <= WS + 1; k++) begin
            chk("rd.busy", 16'(busy), 16'h1);
            chk("rd.dv",   16'(dout_valid), 16'((k == WS + 1) ? 1 : 0));
            if (k == WS + 1) chk("rd.dout", 16'(dout), 16'(exp));
            tick();
        end
        chk("rd.busy_end", 16'(busy), 16'h0);
        chk("rd.dv_end",   16'(dout_valid), 16'h0);
    endtask

    // I/O access; ack is sampled on the d-th edge after acceptance, d>TMO means never
    task automatic io_access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                             input int d, input logic [7:0] rd);
        bit timed_out;
        timed_out = (d > TMO);
        mem_read = !we; mem_write = we; abus = a; din = wd;
        tick();
        mem_read = 1'b0; mem_write = 1'b0; din = ~wd;
        for (int k = 1; k <= TMO; k++) begin
            if (k == d) begin io_ack = 1'b1; io_rdata = rd; end
            chk("io.req",  16'(io_req),  16'h1);
            chk("io.addr", 16'(io_addr), 16'(a[7:0]));
            chk("io.we",   16'(io_we),   16'(we));
            chk("io.busy", 16'(busy),    16'h1);
            if (we) chk("io.wdata", 16'(io_wdata), 16'(wd));
            tick();
            io_ack = 1'b0; io_rdata = 8'h00;
            if (k == d) break;
        end
        chk("io.req_drop", 16'(io_req), 16'h0);
        chk("io.err",      16'(err),    16'(timed_out));
        if (!we) begin
            chk("io.dv",   16'(dout_valid), 16'h1);
            chk("io.dout", 16'(dout), timed_out ? 16'hFF : 16'(rd));
            chk("io.busy_done", 16'(busy), 16'h1);
            tick();
        end else begin
            chk("io.dv_wr", 16'(dout_valid), 16'h0);
        end
        chk("io.busy_end", 16'(busy), 16'h0);
        chk("io.dv_end",   16'(dout_valid), 16'h0);
    endtask

    initial begin
        // Reset values
        reset = 1'b0;
        tick(); tick();
        chk_reset_vals("reset");
        reset = 1'b1;
        tick();

        // Directed RAM write then read with wait states
        ram_write(16'h0010, 8'hA5);
        ram_read(16'h0010);

        // Out-of-range read and write
        mem_read = 1'b1; abus = 16'h2000;
        tick();
        mem_read = 1'b0;
        chk("oob.err",  16'(err), 16'h1);
        chk("oob.dv",   16'(dout_valid), 16'h1);
        chk("oob.dout", 16'(dout), 16'h00);
        tick();
        chk("oob.busy_end", 16'(busy), 16'h0);
        mem_write = 1'b1; abus = 16'h2000; din = 8'h11;
        tick();
        mem_write = 1'b0;
        chk("oobw.err",  16'(err), 16'h1);
        chk("oobw.busy", 16'(busy), 16'h0);
        chk("oobw.dv",   16'(dout_valid), 16'h0);
        tick();
        chk("oobw.err_clr", 16'(err), 16'h0);

        // Both strobes together
        mem_read = 1'b1; mem_write = 1'b1; abus = 16'h0010; din = 8'h00;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        chk("both.err",  16'(err), 16'h1);
        chk("both.busy", 16'(busy), 16'h0);
        chk("both.dv",   16'(dout_valid), 16'h0);
        tick();
        chk("both.err_clr", 16'(err), 16'h0);

        // Strobe during a RAM wait: rejected, original read unaffected
        mem_read = 1'b1; abus = 16'h0010;
        tick();
        mem_read = 1'b0;
        mem_write = 1'b1; din = 8'h5A;
        tick();
        mem_write = 1'b0;
        chk("bsy.err",  16'(err), 16'h1);
        chk("bsy.busy", 16'(busy), 16'h1);
        chk("bsy.dv",   16'(dout_valid), 16'h0);
        tick();
        chk("bsy.dv2",  16'(dout_valid), 16'h1);
        chk("bsy.dout", 16'(dout), 16'hA5);
        chk("bsy.err_clr", 16'(err), 16'h0);
        tick();
        chk("bsy.busy_end", 16'(busy), 16'h0);
        ram_read(16'h0010);   // rejected write must not have landed

        // I/O: directed read, write timeout, read timeout, ack on the timeout edge
        io_access(1'b0, 16'hFF04, 8'h00, 4, 8'h3C);
        io_access(1'b1, 16'hFF20, 8'h5A, TMO + 1, 8'h00);
        io_access(1'b0, 16'hFF33, 8'h00, TMO + 1, 8'h00);
        io_access(1'b0, 16'hFF81, 8'h00, TMO, 8'hC7);
        io_access(1'b1, 16'hFFFF, 8'h99, 1, 8'h00);

        // Prefill the window with back-to-back writes, then random traffic
        for (int a = 0; a < NWIN; a++) ram_write(16'(a), 8'($urandom));
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3)
                ram_write(16'($urandom_range(0, NWIN - 1)), 8'($urandom));
            else if (op <= 6)
                ram_read(16'($urandom_range(0, NWIN - 1)));
            else if (op <= 8)
                io_access(1'b0, 16'hFF00 | 16'($urandom_range(0, 255)), 8'h00,
                          $urandom_range(1, TMO), 8'($urandom));
            else
                io_access(1'b1, 16'hFF00 | 16'($urandom_range(0, 255)), 8'($urandom),
                          $urandom_range(1, TMO + 3), 8'h00);
        end

        // Reset in the middle of an I/O wait, then a late ack
        mem_read = 1'b1; abus = 16'hFF10;
        tick();
        mem_read = 1'b0;
        chk("rst.req_before", 16'(io_req), 16'h1);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_reset_vals("rst_mid");
        reset = 1'b1; io_ack = 1'b1; io_rdata = 8'h77;
        tick();
        io_ack = 1'b0;
        chk("late.req",  16'(io_req), 16'h0);
        chk("late.busy", 16'(busy), 16'h0);
        chk("late.dv",   16'(dout_valid), 16'h0);
        chk("late.err",  16'(err), 16'h0);
        tick();
        chk("late.dv2",  16'(dout_valid), 16'h0);
        // RAM contents survive reset
        ram_read(16'h0010);
        ram_read(16'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
